// File: rtl/mux_sel_sequencer_pkg.sv
// mux_sel_sequencer_pkg: shared select codes, switch encodings and select-step helper
package mux_sel_sequencer_pkg;
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;
  typedef enum logic {MODE_MANUAL = 1'b0, MODE_AUTO = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  function automatic logic [1:0] next_sel(input logic [1:0] s, input dir_e dir);
    return (dir == DIR_DOWN) ? s - 2'd1 : s + 2'd1;
  endfunction
endpackage

// File: rtl/mux_sel_sequencer_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and press detector for one raw button
//   i_clk, i_rst_n : clock, async active-low reset
//   i_raw          : raw bouncy active-high button
//   o_level        : debounced level
//   o_press        : one-cycle pulse after the debounced level rises
module btn_debounce
  import mux_sel_sequencer_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);
  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          w_diff;
  logic          w_done;
  assign w_diff = r_sync[1] != r_level;
  // the DEB_CYCLES-th consecutive mismatching sample commits the new level
  assign w_done = w_diff && (r_cnt == CW'(DEB_CYCLES - 1));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_cnt   <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
      r_level <= w_done ? r_sync[1] : r_level;
      r_press <= w_done && r_sync[1];
    end
  end
  assign o_level = r_level;
  assign o_press = r_press;
endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: debounced button/switch front end producing EN and a stepping 2-bit select
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_step_btn, i_en_btn  : raw bouncy pushbuttons (step, enable toggle)
//   i_mode, i_dir         : slide switches (0 manual / 1 auto, 0 up / 1 down)
//   o_en, o_s             : registered selector enable and code
//   o_step_pulse          : one-cycle strobe in the cycle o_s takes its new value
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned SCAN_DIV   = 50000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step_btn,
  input  logic       i_en_btn,
  input  logic       i_mode,
  input  logic       i_dir,
  output logic       o_en,
  output logic [1:0] o_s,
  output logic       o_step_pulse
);
  localparam int unsigned PW = $clog2(SCAN_DIV);
  logic [1:0]    r_mode_sync;
  logic [1:0]    r_dir_sync;
  logic [PW-1:0] r_presc;
  logic          r_en;
  logic [1:0]    r_s;
  logic          r_pulse;
  logic          w_step_press;
  logic          w_en_press;
  logic [1:0]    w_unused_levels;
  logic          w_auto;
  logic          w_scan;
  logic          w_tick;
  logic          w_advance;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_step_btn),
    .o_level (w_unused_levels[0]),
    .o_press (w_step_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_en_deb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_en_btn),
    .o_level (w_unused_levels[1]),
    .o_press (w_en_press)
  );
  assign w_auto    = mode_e'(r_mode_sync[1]) == MODE_AUTO;
  // prescaler only runs while scanning; any pause restarts a full period
  assign w_scan    = w_auto && r_en;
  assign w_tick    = w_scan && (r_presc == PW'(SCAN_DIV - 1));
  // uses the pre-toggle EN so a same-cycle EN press cannot block or enable this step
  assign w_advance = r_en && (w_auto ? w_tick : w_step_press);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode_sync <= '0;
      r_dir_sync  <= '0;
      r_presc     <= '0;
      r_en        <= 1'b0;
      r_s         <= SEL_A;
      r_pulse     <= 1'b0;
    end else begin
      r_mode_sync <= {r_mode_sync[0], i_mode};
      r_dir_sync  <= {r_dir_sync[0], i_dir};
      r_presc     <= (w_scan && !w_tick) ? r_presc + 1'b1 : '0;
      r_en        <= w_en_press ? !r_en : r_en;
      r_s         <= w_advance ? next_sel(r_s, dir_e'(r_dir_sync[1])) : r_s;
      r_pulse     <= w_advance;
    end
  end
  assign o_en         = r_en;
  assign o_s          = r_s;
  assign o_step_pulse = r_pulse;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: directed scenarios plus randomized button/switch traffic against a reference model
module tb_mux_sel_sequencer;
  localparam int DEB = 4;
  localparam int DIV = 8;
  logic       clk = 0, rst_n = 1, step_btn = 0, en_btn = 0, mode = 0, dir = 0;
  logic       o_en, o_step_pulse;
  logic [1:0] o_s;
  int         errors = 0, checks = 0;
  always #5 clk = ~clk;
  mux_sel_sequencer #(.DEB_CYCLES(DEB), .SCAN_DIV(DIV)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_step_btn   (step_btn),
    .i_en_btn     (en_btn),
    .i_mode       (mode),
    .i_dir        (dir),
    .o_en         (o_en),
    .o_s          (o_s),
    .o_step_pulse (o_step_pulse)
  );
  // Reference model: inputs reach the logic two edges late; a button level is accepted after
  // DEB consecutive differing samples; auto mode ticks every DIV-th consecutive scanning cycle.
  bit         mq_step[$], mq_en[$], mq_mode[$], mq_dir[$];
  bit         m_en, m_pulse, lv_step, lv_en, ev_step, ev_en;
  logic [1:0] m_s;
  int         run_step, run_en, act;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_step = {1'b0, 1'b0}; mq_en = {1'b0, 1'b0};
      mq_mode = {1'b0, 1'b0}; mq_dir = {1'b0, 1'b0};
      m_en = 0; m_s = 0; m_pulse = 0; lv_step = 0; lv_en = 0;
      ev_step = 0; ev_en = 0; run_step = 0; run_en = 0; act = 0;
    end else begin
      bit ms, tick, adv;
      ms = mq_mode[0];
      tick = 0;
      if (ms && m_en) begin
        tick = (act % DIV) == DIV - 1;
        act++;
      end else act = 0;
      adv = m_en && (ms ? tick : ev_step);
      m_pulse = adv;
      if (adv) m_s = mq_dir[0] ? m_s - 2'd1 : m_s + 2'd1;
      if (ev_en) m_en = !m_en;
      ev_step = 0;
      if (mq_step[0] != lv_step) begin
        run_step++;
        if (run_step == DEB) begin lv_step = !lv_step; run_step = 0; ev_step = lv_step; end
      end else run_step = 0;
      ev_en = 0;
      if (mq_en[0] != lv_en) begin
        run_en++;
        if (run_en == DEB) begin lv_en = !lv_en; run_en = 0; ev_en = lv_en; end
      end else run_en = 0;
      void'(mq_step.pop_front()); mq_step.push_back(step_btn);
      void'(mq_en.pop_front());   mq_en.push_back(en_btn);
      void'(mq_mode.pop_front()); mq_mode.push_back(mode);
      void'(mq_dir.pop_front());  mq_dir.push_back(dir);
    end
  end
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic press_step();
    step_btn = 1; cyc(9); step_btn = 0; cyc(9);
  endtask
  task automatic press_en();
    en_btn = 1; cyc(9); en_btn = 0; cyc(9);
  endtask
  task automatic test_reset();
    #2 rst_n = 0; #1;
    checks++;
    if ({o_en, o_s, o_step_pulse} !== 4'b0) begin
      errors++; $display("FAIL reset_state: en/s/pulse=%b/%0d/%b required 0/0/0", o_en, o_s, o_step_pulse);
    end
    @(posedge clk); #1 rst_n = 1;
    cyc(6);
    checks++;
    if ({o_en, o_s, o_step_pulse} !== 4'b0) begin
      errors++; $display("FAIL reset_idle: en/s/pulse=%b/%0d/%b required 0/0/0", o_en, o_s, o_step_pulse);
    end
  endtask
  task automatic test_en_and_step();
    int first = 0;
    en_btn = 1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (o_en && first == 0) first = i;
    end
    en_btn = 0; cyc(10);
    checks++;
    if (first !== 7) begin errors++; $display("FAIL en_latency: edge=%0d required 7", first); end
    for (int p = 1; p <= 4; p++) begin
      int pulses = 0, at = 0;
      logic [1:0] want;
      want = 2'(p);
      step_btn = 1;
      for (int i = 1; i <= 10; i++) begin
        cyc(1);
        if (o_step_pulse) begin pulses++; if (at == 0) at = i; end
      end
      step_btn = 0;
      for (int i = 0; i < 9; i++) begin cyc(1); if (o_step_pulse) pulses++; end
      checks++;
      if (o_s !== want) begin errors++; $display("FAIL manual_s%0d: s=%0d required %0d", p, o_s, want); end
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL manual_pulses%0d: got %0d required 1", p, pulses); end
      checks++;
      if (at !== 7) begin errors++; $display("FAIL step_latency%0d: edge=%0d required 7", p, at); end
    end
  endtask
  task automatic test_bounce();
    int pulses = 0, at = 0;
    bit pat [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step_btn = pat[i]; cyc(1);
      if (o_step_pulse) pulses++;
    end
    step_btn = 1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (o_step_pulse) begin pulses++; if (at == 0) at = i; end
    end
    step_btn = 0;
    for (int i = 0; i < 9; i++) begin cyc(1); if (o_step_pulse) pulses++; end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d required 1", pulses); end
    checks++;
    if (at !== 7) begin errors++; $display("FAIL bounce_latency: edge=%0d required 7", at); end
    checks++;
    if (o_s !== 2'd1) begin errors++; $display("FAIL bounce_s: s=%0d required 1", o_s); end
  endtask
  task automatic test_auto();
    int t [3];
    logic [1:0] v [3];
    int n = 0;
    dir = 1;
    for (int k = 0; k < 4 && m_s != 0; k++) press_step();
    checks++;
    if (o_s !== 2'd0) begin errors++; $display("FAIL auto_setup: s=%0d required 0", o_s); end
    mode = 1;
    for (int i = 1; i <= 40; i++) begin
      step_btn = ((i / 5) % 2) == 1;
      cyc(1);
      if (o_step_pulse && n < 3) begin t[n] = i; v[n] = o_s; n++; end
    end
    step_btn = 0;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL auto_ticks: got %0d required 3", n); end
    else begin
      checks++;
      if ({v[0], v[1], v[2]} !== {2'd3, 2'd2, 2'd1}) begin
        errors++; $display("FAIL auto_seq: got %0d,%0d,%0d required 3,2,1", v[0], v[1], v[2]);
      end
      checks++;
      if (t[1] - t[0] !== 8 || t[2] - t[1] !== 8) begin
        errors++; $display("FAIL auto_spacing: got %0d,%0d required 8,8", t[1] - t[0], t[2] - t[1]);
      end
    end
    cyc(8);
    checks++;
    if ({o_en, o_s} !== {m_en, m_s}) begin
      errors++; $display("FAIL auto_model: en/s=%b/%0d required %b/%0d", o_en, o_s, m_en, m_s);
    end
  endtask
  task automatic test_disable();
    logic [1:0] s0;
    int pulses = 0, bad_presc = 0, wait_en = 0, k = 0;
    en_btn = 1; cyc(10); en_btn = 0;
    checks++;
    if (o_en !== 1'b0) begin errors++; $display("FAIL disable_en: en=%b required 0", o_en); end
    s0 = o_s;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (o_step_pulse) pulses++;
      if (dut.r_presc !== '0) bad_presc++;
    end
    checks++;
    if (o_s !== s0 || pulses !== 0) begin
      errors++; $display("FAIL frozen: s=%0d pulses=%0d required s=%0d pulses=0", o_s, pulses, s0);
    end
    checks++;
    if (bad_presc !== 0) begin errors++; $display("FAIL presc_hold: nonzero %0d cycles required 0", bad_presc); end
    en_btn = 1;
    while (!o_en && wait_en < 12) begin cyc(1); wait_en++; end
    checks++;
    if (!o_en) begin errors++; $display("FAIL reenable: en=%b required 1", o_en); end
    else begin
      while (!o_step_pulse && k < 20) begin cyc(1); k++; end
      checks++;
      if (k !== 8) begin errors++; $display("FAIL first_tick: edge=%0d required 8", k); end
    end
    en_btn = 0; cyc(9);
  endtask
  task automatic test_simultaneous();
    int at = 0;
    logic [1:0] s_at;
    logic en_at;
    mode = 0; dir = 0; cyc(3);
    if (!m_en) press_en();
    for (int k = 0; k < 4 && m_s != 1; k++) press_step();
    checks++;
    if ({o_en, o_s} !== 3'b101) begin errors++; $display("FAIL simul_setup: en/s=%b/%0d required 1/1", o_en, o_s); end
    step_btn = 1; en_btn = 1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (o_step_pulse && at == 0) begin at = i; s_at = o_s; en_at = o_en; end
    end
    step_btn = 0; en_btn = 0; cyc(9);
    checks++;
    if (at !== 7) begin errors++; $display("FAIL simul_edge: edge=%0d required 7", at); end
    else begin
      checks++;
      if ({en_at, s_at} !== 3'b010) begin
        errors++; $display("FAIL simul_result: en/s=%b/%0d required 0/2", en_at, s_at);
      end
    end
  endtask
  task automatic test_random();
    int hs = 0, he = 0;
    for (int i = 0; i < 800; i++) begin
      if (hs == 0) begin step_btn = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 12); end else hs--;
      if (he == 0) begin en_btn = 1'($urandom_range(0, 1)); he = $urandom_range(1, 14); end else he--;
      if ($urandom_range(0, 59) == 0) mode = !mode;
      if ($urandom_range(0, 19) == 0) dir = !dir;
      cyc(1);
      checks++;
      if ({o_en, o_s, o_step_pulse} !== {m_en, m_s, m_pulse}) begin
        errors++;
        $display("FAIL random_cycle%0d: en/s/pulse=%b/%0d/%b required %b/%0d/%b",
                 i, o_en, o_s, o_step_pulse, m_en, m_s, m_pulse);
      end
    end
    step_btn = 0; en_btn = 0; cyc(10);
  endtask
  task automatic test_reset_midrun();
    mode = 0; dir = 0; cyc(3);
    if (!m_en) press_en();
    for (int k = 0; k < 4 && m_s != 2; k++) press_step();
    checks++;
    if ({o_en, o_s} !== 3'b110) begin errors++; $display("FAIL midreset_setup: en/s=%b/%0d required 1/2", o_en, o_s); end
    #2 rst_n = 0; #1;
    checks++;
    if ({o_en, o_s, o_step_pulse} !== 4'b0) begin
      errors++; $display("FAIL midreset_async: en/s/pulse=%b/%0d/%b required 0/0/0", o_en, o_s, o_step_pulse);
    end
    @(posedge clk); #1 rst_n = 1;
    cyc(8);
    checks++;
    if ({o_en, o_s, o_step_pulse} !== 4'b0) begin
      errors++; $display("FAIL midreset_idle: en/s/pulse=%b/%0d/%b required 0/0/0", o_en, o_s, o_step_pulse);
    end
  endtask
  initial begin
    test_reset();
    test_en_and_step();
    test_bounce();
    test_auto();
    test_disable();
    test_simultaneous();
    test_random();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
